// File: rtl/dcache_flush_walker.sv
// Flush/fence walker for the dcache (dirty,valid) state array: visits every set
// once, writes back dirty+valid lines, then cleans or invalidates them in place.
module dcache_flush_walker #(
  parameter int AW = 5,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_req,
  input  logic          inval,
  output logic          busy,
  output logic          done,
  output logic [AW+2:0] wb_count,
  output logic [AW-1:0] sram_index,
  output logic [1:0]    sram_way,
  output logic [DW-1:0] sram_din,
  output logic          sram_we,
  output logic          sram_en,
  input  logic [DW-1:0] sram_dout0,
  input  logic [DW-1:0] sram_dout1,
  input  logic [DW-1:0] sram_dout2,
  input  logic [DW-1:0] sram_dout3,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_index,
  output logic [1:0]    wb_way
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_WB, S_CLR, S_NEXT, S_DONE
  } state_e;

  state_e               state_q;
  logic                 inval_q;
  logic [AW-1:0]        idx_q;
  logic [1:0]           way_q;
  logic [3:0][DW-1:0]   st_q;
  logic [AW+2:0]        wb_cnt_q;
  logic                 busy_q, done_q, wb_valid_q, sram_en_q, sram_we_q;
  logic [AW-1:0]        sram_index_q, wb_index_q;
  logic [1:0]           sram_way_q, wb_way_q;
  logic [DW-1:0]        sram_din_q;

  logic [DW-1:0]        cur_d;
  logic                 last_way_d;
  logic                 last_set_d;
  logic [DW-1:0]        clr_din_d;

  assign cur_d      = st_q[way_q];
  assign last_way_d = (way_q == 2'd3);
  assign last_set_d = (idx_q == {AW{1'b1}});
  assign clr_din_d  = inval_q ? DW'(0) : DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inval_q      <= 1'b0;
      idx_q        <= '0;
      way_q        <= '0;
      st_q         <= '0;
      wb_cnt_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_din_q   <= '0;
      sram_index_q <= '0;
      sram_way_q   <= '0;
      wb_index_q   <= '0;
      wb_way_q     <= '0;
    end else begin
      // Array strobes are single-cycle; states that need them re-assert below.
      sram_en_q  <= 1'b0;
      sram_we_q  <= 1'b0;
      sram_din_q <= '0;
      done_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            inval_q      <= inval;
            idx_q        <= '0;
            way_q        <= '0;
            wb_cnt_q     <= '0;
            busy_q       <= 1'b1;
            sram_en_q    <= 1'b1;
            sram_index_q <= '0;
            sram_way_q   <= '0;
            state_q      <= S_READ;
          end
        end
        S_READ: begin
          st_q    <= {sram_dout3, sram_dout2, sram_dout1, sram_dout0};
          way_q   <= '0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          // A dirty-but-invalid line (10) is treated as absent.
          if (cur_d[1] && cur_d[0]) begin
            wb_valid_q <= 1'b1;
            wb_index_q <= idx_q;
            wb_way_q   <= way_q;
            state_q    <= S_WB;
          end else if (inval_q && cur_d[0]) begin
            sram_en_q    <= 1'b1;
            sram_we_q    <= 1'b1;
            sram_index_q <= idx_q;
            sram_way_q   <= way_q;
            sram_din_q   <= clr_din_d;
            state_q      <= S_CLR;
          end else if (last_way_d) begin
            state_q <= S_NEXT;
          end else begin
            way_q <= way_q + 2'd1;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid_q   <= 1'b0;
            wb_cnt_q     <= wb_cnt_q + (AW+3)'(1);
            sram_en_q    <= 1'b1;
            sram_we_q    <= 1'b1;
            sram_index_q <= idx_q;
            sram_way_q   <= way_q;
            sram_din_q   <= clr_din_d;
            state_q      <= S_CLR;
          end
        end
        S_CLR: begin
          if (last_way_d) begin
            state_q <= S_NEXT;
          end else begin
            way_q   <= way_q + 2'd1;
            state_q <= S_CHECK;
          end
        end
        S_NEXT: begin
          if (last_set_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q        <= idx_q + AW'(1);
            sram_en_q    <= 1'b1;
            sram_index_q <= idx_q + AW'(1);
            sram_way_q   <= '0;
            state_q      <= S_READ;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wb_count   = wb_cnt_q;
  assign sram_index = sram_index_q;
  assign sram_way   = sram_way_q;
  assign sram_din   = sram_din_q;
  assign sram_we    = sram_we_q;
  assign sram_en    = sram_en_q;
  assign wb_valid   = wb_valid_q;
  assign wb_index   = wb_index_q;
  assign wb_way     = wb_way_q;

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Directed bench for dcache_flush_walker (AW=2): behavioural state array,
// ready-delay writeback sink, handshake/write logs and immediate-assert checks.
module tb_dcache_flush_walker;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, flush_req, inval;
  logic          busy, done, sram_we, sram_en, wb_valid, wb_ready;
  logic [AW+2:0] wb_count;
  logic [AW-1:0] sram_index, wb_index;
  logic [1:0]    sram_way, sram_din, wb_way;
  logic [1:0]    sram_dout0, sram_dout1, sram_dout2, sram_dout3;

  logic [3:0][3:0][1:0] mem, load_img;
  logic                 load_en;
  int                   delay, hold_cnt;
  logic [3:0]           wb_log[$];
  logic [5:0]           wr_log[$];
  int                   rd_cnt, done_cnt, stab_err;
  logic                 pend_q;
  logic [3:0]           pend_id_q;
  int                   checks, failures;

  always #5 clk = ~clk;

  dcache_flush_walker #(.AW(AW), .DW(2)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .inval(inval),
    .busy(busy), .done(done), .wb_count(wb_count),
    .sram_index(sram_index), .sram_way(sram_way), .sram_din(sram_din),
    .sram_we(sram_we), .sram_en(sram_en),
    .sram_dout0(sram_dout0), .sram_dout1(sram_dout1),
    .sram_dout2(sram_dout2), .sram_dout3(sram_dout3),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_index(wb_index), .wb_way(wb_way)
  );

  assign sram_dout0 = mem[sram_index][0];
  assign sram_dout1 = mem[sram_index][1];
  assign sram_dout2 = mem[sram_index][2];
  assign sram_dout3 = mem[sram_index][3];
  assign wb_ready   = wb_valid && (hold_cnt >= delay);

  always @(posedge clk) begin
    if (load_en) mem <= load_img;
    else if (sram_en && sram_we) mem[sram_index][sram_way] <= sram_din;
  end

  initial begin
    hold_cnt = 0; rd_cnt = 0; done_cnt = 0; stab_err = 0; pend_q = 1'b0; pend_id_q = '0;
  end

  always @(posedge clk) begin
    if (sram_en && sram_we) wr_log.push_back({sram_index, sram_way, sram_din});
    if (sram_en && !sram_we) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (wb_valid && wb_ready) wb_log.push_back({wb_index, wb_way});
    if (pend_q && (!wb_valid || {wb_index, wb_way} != pend_id_q)) stab_err <= stab_err + 1;
    pend_q    <= wb_valid && !wb_ready;
    pend_id_q <= {wb_index, wb_way};
    if (wb_valid && !wb_ready) hold_cnt <= hold_cnt + 1;
    else hold_cnt <= 0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0][3:0][1:0] img);
    @(negedge clk);
    load_img = img;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Start a flush and count cycles from the sampling edge until done is seen.
  task automatic run_flush(input logic inv, input int dly, input bit repulse, output int lat);
    @(negedge clk);
    inval = inv; delay = dly; flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 500) begin
      flush_req = (repulse && lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    flush_req = 1'b0;
  endtask

  initial begin
    int lat, wb0, wr0, rd0, dn0, st0, n;
    logic [3:0][3:0][1:0] img;
    checks = 0; failures = 0;
    rst = 1'b1; flush_req = 1'b0; inval = 1'b0; delay = 0;
    load_en = 1'b0; load_img = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_wb_count", wb_count, 0);
    chk("rst_outs", {sram_index, sram_way, sram_din, wb_index, wb_way}, 0);
    @(negedge clk); rst = 1'b0;
    load('0);

    // 1: empty array
    wb0 = wb_log.size(); wr0 = wr_log.size(); rd0 = rd_cnt;
    run_flush(1'b0, 0, 1'b0, lat);
    chk("t1_latency", lat, 24);
    chk("t1_wb_none", wb_log.size() - wb0, 0);
    chk("t1_wr_none", wr_log.size() - wr0, 0);
    chk("t1_reads", rd_cnt - rd0, 4);
    chk("t1_wb_count", wb_count, 0);
    chk("t1_busy_in_done", busy, 0);

    // 2: one dirty line, clean mode, ready delayed 3 cycles
    img = '0; img[1][2] = 2'b11;
    load(img);
    wb0 = wb_log.size(); wr0 = wr_log.size(); st0 = stab_err;
    run_flush(1'b0, 3, 1'b0, lat);
    chk("t2_latency", lat, 29);
    chk("t2_wb_n", wb_log.size() - wb0, 1);
    if (wb_log.size() > wb0) chk("t2_wb_id", wb_log[wb0], {2'd1, 2'd2});
    chk("t2_wr_n", wr_log.size() - wr0, 1);
    if (wr_log.size() > wr0) chk("t2_wr", wr_log[wr0], {2'd1, 2'd2, 2'b01});
    chk("t2_stable", stab_err - st0, 0);
    chk("t2_wb_count", wb_count, 1);
    chk("t2_mem", mem[1][2], 2'b01);

    // 3: invalidate mode, mixed line states
    img = '0; img[0][0] = 2'b01; img[3][3] = 2'b11; img[2][1] = 2'b10;
    load(img);
    wb0 = wb_log.size(); wr0 = wr_log.size();
    run_flush(1'b1, 0, 1'b0, lat);
    chk("t3_latency", lat, 27);
    chk("t3_wb_n", wb_log.size() - wb0, 1);
    if (wb_log.size() > wb0) chk("t3_wb_id", wb_log[wb0], {2'd3, 2'd3});
    chk("t3_wr_n", wr_log.size() - wr0, 2);
    if (wr_log.size() > wr0 + 1) begin
      chk("t3_wr0", wr_log[wr0], {2'd0, 2'd0, 2'b00});
      chk("t3_wr1", wr_log[wr0+1], {2'd3, 2'd3, 2'b00});
    end
    chk("t3_untouched", mem[2][1], 2'b10);
    chk("t3_wb_count", wb_count, 1);

    // 4: every line dirty, invalidate, ready always high
    img = '1;
    load(img);
    wb0 = wb_log.size(); wr0 = wr_log.size();
    run_flush(1'b1, 0, 1'b0, lat);
    chk("t4_latency", lat, 56);
    chk("t4_wb_n", wb_log.size() - wb0, 16);
    chk("t4_wr_n", wr_log.size() - wr0, 16);
    n = (wb_log.size() - wb0 < 16) ? wb_log.size() - wb0 : 16;
    for (int k = 0; k < n; k++) chk($sformatf("t4_order%0d", k), wb_log[wb0+k], k);
    for (int k = 0; k < 16 && wr0 + k < wr_log.size(); k++)
      chk($sformatf("t4_din%0d", k), wr_log[wr0+k][1:0], 0);
    chk("t4_mem_clear", (mem == '0) ? 1 : 0, 1);
    chk("t4_wb_count", wb_count, 16);

    // 5: reset while stalled in writeback, then restart
    img = '0; img[0][0] = 2'b11;
    load(img);
    @(negedge clk);
    inval = 1'b0; delay = 1000; flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("t5_reach_wb", wb_valid, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr0 = wr_log.size();
    @(posedge clk); #1;
    chk("t5_wb_valid", wb_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_sram_we", sram_we, 0);
    chk("t5_no_write", wr_log.size() - wr0, 0);
    @(negedge clk); rst = 1'b0;
    wb0 = wb_log.size();
    run_flush(1'b0, 0, 1'b0, lat);
    chk("t5_latency", lat, 26);
    chk("t5_wb_n", wb_log.size() - wb0, 1);
    if (wb_log.size() > wb0) chk("t5_wb_id", wb_log[wb0], 0);
    chk("t5_wb_count", wb_count, 1);
    chk("t5_mem", mem[0][0], 2'b01);

    // 6: flush_req re-pulsed while busy
    load('0);
    dn0 = done_cnt;
    run_flush(1'b0, 0, 1'b1, lat);
    chk("t6_latency", lat, 24);
    repeat (40) @(posedge clk);
    #1;
    chk("t6_one_done", done_cnt - dn0, 1);
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
